// File: rtl/fp_wb_arbiter_if.sv
// Bus bundle between the FP writeback arbiter and its neighbours: the
// single-cycle result port (A), the multi-cycle FPU port (B), the
// scoreboard query, and the register file write port.
interface fp_wb_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Port A: single-cycle FP ops
  logic          a_valid;
  logic [4:0]    a_rd;
  logic [31:0]   a_data;
  // Port B: multi-cycle FPU results
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_rd;
  logic [31:0]   b_data;
  // Scoreboard query and flow control
  logic [4:0]    chk_rd;
  logic          chk_busy;
  logic          stall_req;
  logic [CW-1:0] fifo_count;
  // Register file write port
  logic [4:0]    A3;
  logic          WE3;
  logic [31:0]   WD3;

  // Arbiter side
  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  chk_rd,
    output b_ready, chk_busy, stall_req, fifo_count,
    output A3, WE3, WD3
  );

  // Producer / consumer side
  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output chk_rd,
    input  b_ready, chk_busy, stall_req, fifo_count,
    input  A3, WE3, WD3
  );
endinterface

// File: rtl/fp_wb_arbiter.sv
// FP writeback arbiter: merges single-cycle results (port A, always wins)
// with buffered multi-cycle FPU results (port B, in-order FIFO) onto the
// register file write port, reports pending destinations to the issue
// scoreboard and requests an upstream stall when the FIFO is starved.
module fp_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int MAX_STARVE = 8
) (
  input logic    clk,
  input logic    rst,
  fp_wb_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  // FIFO storage; read combinationally at the head so a pop can be
  // selected in the same cycle it is decided.
  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [SW-1:0] starve_reg;
  logic [SW-1:0] starve_next;
  logic          stall_reg;
  logic          stall_next;
  logic          we_reg;
  logic [4:0]    a3_reg;
  logic [31:0]   wd_reg;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          sel_valid;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic [DEPTH-1:0] hit;

  // Full is judged on the pre-edge count only, so a same-cycle pop never
  // opens a slot for a push.
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == DEPTH_C);
  assign push      = bus.b_valid && !full;
  assign pop       = !bus.a_valid && !empty;
  assign sel_valid = bus.a_valid || !empty;
  assign sel_rd    = bus.a_valid ? bus.a_rd   : rd_mem[rd_ptr_reg];
  assign sel_data  = bus.a_valid ? bus.a_data : data_mem[rd_ptr_reg];

  // Occupancy update: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Starvation counter saturates at the limit; stall holds until a pop
  always_comb begin
    starve_next = starve_reg;
    if (pop || empty) begin
      starve_next = '0;
    end else if (bus.a_valid && (starve_reg != STARVE_MAX)) begin
      starve_next = starve_reg + SW'(1);
    end
    stall_next = (starve_next == STARVE_MAX) || (stall_reg && !pop);
  end

  // FIFO payload write; contents need no reset because occupancy gates use
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= bus.b_rd;
      data_mem[wr_ptr_reg] <= bus.b_data;
    end
  end

  // FIFO pointers, occupancy and starvation state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
      stall_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg  <= count_next;
      starve_reg <= starve_next;
      stall_reg  <= stall_next;
    end
  end

  // Write-port register: x0 destinations burn the slot without writing
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg <= 1'b0;
      a3_reg <= '0;
      wd_reg <= '0;
    end else if (sel_valid) begin
      we_reg <= (sel_rd != 5'd0);
      a3_reg <= sel_rd;
      wd_reg <= sel_data;
    end else begin
      we_reg <= 1'b0;
    end
  end

  // Per-slot destination match, masked to the live window of the FIFO
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      logic [PW-1:0] offset;
      assign offset  = PW'(gi) - rd_ptr_reg;
      assign hit[gi] = ({1'b0, offset} < count_reg) && (rd_mem[gi] == bus.chk_rd);
    end
  endgenerate

  assign bus.chk_busy   = (bus.chk_rd != 5'd0) &&
                          ((|hit) || (we_reg && (a3_reg == bus.chk_rd)));
  assign bus.b_ready    = !full;
  assign bus.fifo_count = count_reg;
  assign bus.stall_req  = stall_reg;
  assign bus.A3         = a3_reg;
  assign bus.WE3        = we_reg;
  assign bus.WD3        = wd_reg;
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench for fp_wb_arbiter: a table of single-cycle vectors,
// hand-written multi-cycle sequences, and a cycle-level reference model
// whose expected register-file writes are queued and matched on output.
module tb_fp_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int MAX_STARVE = 8;

  logic clk;
  logic rst;
  fp_wb_if #(.DEPTH(DEPTH)) bus();

  fp_wb_arbiter #(.DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bdat,
                       input logic [4:0] crd);
    bus.a_valid = av;
    bus.a_rd    = ard;
    bus.a_data  = adat;
    bus.b_valid = bv;
    bus.b_rd    = brd;
    bus.b_data  = bdat;
    bus.chk_rd  = crd;
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_fifo[$];
  ent_t        exp_q[$];
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  int          m_starve;
  bit          m_stall;
  ent_t        m_sel;
  bit          m_has_sel, m_pre_empty, m_pre_full, m_pop, m_push;

  // Spec-level model: A wins, else FIFO head pops; push only when not full
  always @(posedge clk) begin
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_we = 1'b0;
      m_a3 = '0;
      m_wd = '0;
      m_starve = 0;
      m_stall = 1'b0;
    end else begin
      m_pre_empty = (m_fifo.size() == 0);
      m_pre_full  = (m_fifo.size() == DEPTH);
      m_push      = bus.b_valid && !m_pre_full;
      m_pop       = 1'b0;
      m_has_sel   = 1'b0;
      if (bus.a_valid) begin
        m_has_sel = 1'b1;
        m_sel     = {bus.a_rd, bus.a_data};
      end else if (!m_pre_empty) begin
        m_has_sel = 1'b1;
        m_pop     = 1'b1;
        m_sel     = m_fifo.pop_front();
      end
      if (m_push) m_fifo.push_back({bus.b_rd, bus.b_data});
      if (m_pop || m_pre_empty) m_starve = 0;
      else if (bus.a_valid && m_starve < MAX_STARVE) m_starve++;
      m_stall = (m_starve == MAX_STARVE) || (m_stall && !m_pop);
      if (m_has_sel) begin
        m_we = (m_sel.rd != 5'd0);
        m_a3 = m_sel.rd;
        m_wd = m_sel.data;
        if (m_sel.rd != 5'd0) exp_q.push_back(m_sel);
      end else begin
        m_we = 1'b0;
      end
    end
  end

  function automatic bit model_busy(input logic [4:0] crd);
    bit b = 1'b0;
    if (crd == 5'd0) return 1'b0;
    foreach (m_fifo[i]) if (m_fifo[i].rd == crd) b = 1'b1;
    if (m_we && m_a3 == crd) b = 1'b1;
    return b;
  endfunction

  // Per-cycle comparison against the model, and scoreboard match on writes
  always @(negedge clk) begin
    ent_t e;
    if (mon_en && !rst) begin
      chk("mon WE3", bus.WE3, m_we);
      if (m_we) begin
        chk("mon A3", bus.A3, m_a3);
        chk("mon WD3", bus.WD3, m_wd);
      end
      chk("mon fifo_count", 32'(bus.fifo_count), 32'(m_fifo.size()));
      chk("mon b_ready", bus.b_ready, m_fifo.size() < DEPTH);
      chk("mon stall_req", bus.stall_req, m_stall);
      chk("mon chk_busy", bus.chk_busy, model_busy(bus.chk_rd));
      if (bus.WE3) begin
        if (exp_q.size() == 0) begin
          chk("sb unexpected write rd", 32'(bus.A3), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("write rd=%0d data=%h", bus.A3, bus.WD3);
          chk("sb rd", bus.A3, e.rd);
          chk("sb data", bus.WD3, e.data);
        end
      end
    end
  end

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bdat;
    logic [4:0]  crd;
    logic        exp_busy;   // chk_busy during the cycle, before the edge
    logic        exp_we;     // outputs after the edge
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'h3F800000, 1'b0, 5'd0, 32'h0,        5'd5, 1'b0, 1'b1, 5'd5, 32'h3F800000, 0};
    vecs[1] = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h0,        5'd5, 1'b1, 1'b0, 5'd0, 32'h0,        0};
    vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 1'b0, 1'b0, 5'd0, 32'h0,        0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hAAAA0001, 5'd9, 1'b0, 1'b0, 5'd0, 32'h0,        1};
    vecs[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 1'b1, 1'b1, 5'd9, 32'hAAAA0001, 0};
    vecs[5] = '{1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444, 5'd9, 1'b1, 1'b1, 5'd3, 32'h33333333, 1};
    vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd4, 1'b1, 1'b1, 5'd4, 32'h44444444, 0};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hDEAD0000, 5'd4, 1'b1, 1'b0, 5'd0, 32'h0,        1};
    vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 1'b0, 1'b0, 5'd0, 32'h0,        0};
    vecs[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd4, 1'b0, 1'b0, 5'd0, 32'h0,        0};

    // ---- reset then idle ----
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset WE3", bus.WE3, 1'b0);
    chk("reset A3", bus.A3, 5'd0);
    chk("reset WD3", bus.WD3, 32'h0);
    chk("reset b_ready", bus.b_ready, 1'b1);
    chk("reset fifo_count", 32'(bus.fifo_count), 0);
    chk("reset stall_req", bus.stall_req, 1'b0);
    mon_en = 1'b1;

    // ---- table ----
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].bv, vecs[i].brd,
            vecs[i].bdat, vecs[i].crd);
      @(negedge clk);
      chk($sformatf("vec%0d chk_busy", i), bus.chk_busy, vecs[i].exp_busy);
      step();
      $display("vec %0d: WE3=%0b A3=%0d WD3=%h count=%0d", i, bus.WE3, bus.A3, bus.WD3, bus.fifo_count);
      chk($sformatf("vec%0d WE3", i), bus.WE3, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d A3", i), bus.A3, vecs[i].exp_a3);
        chk($sformatf("vec%0d WD3", i), bus.WD3, vecs[i].exp_wd);
      end
      chk($sformatf("vec%0d fifo_count", i), 32'(bus.fifo_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d b_ready", i), bus.b_ready, vecs[i].exp_cnt < DEPTH);
    end

    // ---- contention: A rd1,2,3 beats buffered B rd7 ----
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h40490FDB, 5'd7);
    @(negedge clk);
    chk("cont busy t", bus.chk_busy, 1'b0);
    step();
    drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'h0, 5'd7);
    @(negedge clk);
    chk("cont busy t+1", bus.chk_busy, 1'b1);
    chk("cont A3 t+1", bus.A3, 5'd1);
    step();
    drive(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'h0, 5'd7);
    @(negedge clk);
    chk("cont busy t+2", bus.chk_busy, 1'b1);
    chk("cont A3 t+2", bus.A3, 5'd2);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7);
    @(negedge clk);
    chk("cont busy t+3", bus.chk_busy, 1'b1);
    chk("cont A3 t+3", bus.A3, 5'd3);
    chk("cont count t+3", 32'(bus.fifo_count), 1);
    step();
    @(negedge clk);
    chk("cont busy t+4", bus.chk_busy, 1'b1);
    chk("cont WE3 t+4", bus.WE3, 1'b1);
    chk("cont A3 t+4", bus.A3, 5'd7);
    chk("cont WD3 t+4", bus.WD3, 32'h40490FDB);
    step();
    @(negedge clk);
    chk("cont busy t+5", bus.chk_busy, 1'b0);
    chk("cont WE3 t+5", bus.WE3, 1'b0);
    step();

    // ---- full FIFO: B rd8..11 accepted, rd12 held until a drain slot ----
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b1, (i < 4) ? 5'(8 + i) : 5'd12, 32'hB000_0000 + 32'(8 + i), 5'd0);
      @(negedge clk);
      chk($sformatf("full b_ready c%0d", i), bus.b_ready, i < 4);
      if (i >= 4) chk($sformatf("full count c%0d", i), 32'(bus.fifo_count), 4);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hB000_000C, 5'd0);
    @(negedge clk);
    chk("full count drain", 32'(bus.fifo_count), 4);
    chk("full b_ready drain", bus.b_ready, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("drain WE3 %0d", i), bus.WE3, 1'b1);
      chk($sformatf("drain A3 %0d", i), bus.A3, 5'(8 + i));
      step();
      bus.b_valid = 1'b0;
    end
    @(negedge clk);
    chk("drain done WE3", bus.WE3, 1'b0);
    step();

    // ---- starvation: one B entry under continuous A traffic ----
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 5'd2, 32'(i), i == 0, 5'd15, 32'hBEEF0015, 5'd15);
      @(negedge clk);
      chk($sformatf("starve stall s%0d", i), bus.stall_req, i >= 9);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd15);
    @(negedge clk);
    chk("starve stall pop cycle", bus.stall_req, 1'b1);
    step();
    @(negedge clk);
    chk("starve stall after pop", bus.stall_req, 1'b0);
    chk("starve WE3", bus.WE3, 1'b1);
    chk("starve A3", bus.A3, 5'd15);
    chk("starve WD3", bus.WD3, 32'hBEEF0015);
    step();

    // ---- reset mid-operation discards buffered entries ----
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd3, 32'h3000_0000 + 32'(i), 1'b1, 5'(20 + i), 32'h2000_0000 + 32'(i), 5'd21);
      step();
    end
    drive(1'b1, 5'd3, 32'h3000_0003, 1'b1, 5'd23, 32'h2000_0003, 5'd21);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst count before", 32'(bus.fifo_count), 3);
    step();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd21);
    @(negedge clk);
    chk("midrst count", 32'(bus.fifo_count), 0);
    chk("midrst WE3", bus.WE3, 1'b0);
    chk("midrst b_ready", bus.b_ready, 1'b1);
    chk("midrst stall", bus.stall_req, 1'b0);
    chk("midrst busy", bus.chk_busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk($sformatf("midrst no write %0d", i), bus.WE3, 1'b0);
    end
    step();

    chk("sb drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Writeback stage directly upstream of the FP register file; drives its single write port (A3/WE3/WD3).
- Merges two result sources onto that port:
  - Port A: single-cycle FP ops. Never stalls, always has priority.
  - Port B: multi-cycle FPU (div/sqrt/fma). Valid/ready handshake, buffered in an internal FIFO.
- Provides a pending-destination check for the issue scoreboard and a starvation stall request.

Parameters:
- DEPTH, 4, B-result FIFO entries; power of 2, >= 2.
- MAX_STARVE, 8, consecutive cycles a non-empty FIFO may lose arbitration before stall_req asserts; >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  port A result valid this cycle.
- a_rd  input  5  port A destination register.
- a_data  input  32  port A result.
- b_valid  input  1  port B result valid.
- b_ready  output  1  FIFO can accept a port B result.
- b_rd  input  5  port B destination register.
- b_data  input  32  port B result.
- chk_rd  input  5  register queried by the scoreboard.
- chk_busy  output  1  chk_rd has a write pending inside this block.
- stall_req  output  1  request for upstream to hold a_valid low.
- fifo_count  output  log2(DEPTH)+1  current FIFO occupancy.
- A3  output  5  register file write address.
- WE3  output  1  register file write enable.
- WD3  output  32  register file write data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - WE3=0, A3=0, WD3=0.
  - FIFO emptied: fifo_count=0, so b_ready=1 in the next cycle.
  - Starve counter=0, stall_req=0.
  - Reset wins over every same-cycle event. In-flight FIFO entries are discarded, not written.
- Push (port B):
  - b_ready = (fifo_count < DEPTH), combinational from state only.
  - Push on b_valid && b_ready.
  - No push-while-full, even if a pop occurs in the same cycle.
- Arbitration: evaluated every cycle on the pre-edge FIFO state.
  - a_valid=1 -> port A is selected. The FIFO head is held and not popped.
  - a_valid=0 and FIFO non-empty -> the head is popped and selected.
  - Neither -> nothing is selected.
  - An entry pushed in cycle t is poppable no earlier than cycle t+1.
  - Same-cycle push and pop on a non-full FIFO: count unchanged, order preserved.
- Output register: the selection is registered.
  - A3/WD3/WE3 take the selected rd/data in the cycle after selection. The register file writes on the following edge.
  - Port A latency: a_valid in cycle t -> WE3=1 in t+1.
  - Port B minimum latency: b_valid accepted in t -> WE3=1 in t+2.
  - Nothing selected -> WE3=0. A3/WD3 hold their previous values.
- x0 suppression: a selected entry with rd=0 still consumes its arbitration slot and is still popped, but WE3=0 for that slot.
- Ordering: the FIFO is strictly in order. No squash on write-after-write between A and a buffered B entry; the scoreboard prevents that hazard using chk_busy.
- chk_busy (combinational) = (chk_rd != 0) && (any valid FIFO entry has rd == chk_rd, OR (WE3 && A3 == chk_rd)).
- Starvation:
  - Counter increments each cycle with a_valid=1 and FIFO non-empty.
  - Counter clears on any pop, or when the FIFO is empty.
  - stall_req is registered. It asserts the cycle after the counter reaches MAX_STARVE and stays high until the cycle after the next pop.
  - Upstream holds a_valid=0 while stall_req=1. If a_valid=1 anyway, A still wins: stall_req stays high and the counter saturates.
- Occupancy: fifo_count wraps never. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> WE3=0, A3=0, WD3=0, b_ready=1, fifo_count=0, stall_req=0.
- Port A only: a_valid=1, a_rd=5, a_data=0x3F800000 at t -> WE3=1, A3=5, WD3=0x3F800000 at t+1. Same with a_rd=0 -> WE3=0 at t+1.
- Contention: A valid every cycle t..t+2 (rd 1,2,3); B pushes rd=7, data 0x40490FDB at t -> writes to rd 1,2,3 at t+1..t+3, then rd 7 at t+4. chk_rd=7 -> chk_busy=1 from t+1 through t+4, and 0 at t+5.
- Full FIFO: a_valid=1 continuously, B pushes rd 8..12 -> b_ready=0 after 4 accepts, fifo_count=4, rd 12 held off. Drop a_valid -> drains 8,9,10,11 in order on consecutive cycles, then rd 12 accepted.
- Starvation (MAX_STARVE=8): one B entry buffered, a_valid=1 for 8 cycles -> stall_req=1 on the next cycle. Upstream drops a_valid -> B entry written, stall_req=0 the cycle after the pop.
- Reset mid-operation: 3 entries buffered, rst=1 for one cycle -> fifo_count=0, WE3=0, and none of the 3 entries is ever written.
